// File: rtl/mux_pkt_arbiter_if.sv
// Handshake bundle between two flit sources, the arbiter and the downstream output mux.
interface mux_pkt_arbiter_if #(
  parameter int SELW = 5,
  parameter int CNTW = 16
);
  logic            ivalid_0;
  logic [1:0]      itype_0;
  logic            ivalid_1;
  logic [1:0]      itype_1;
  logic            ordy;
  logic [SELW-1:0] sel;
  logic            grant_0;
  logic            grant_1;
  logic            busy;
  logic            err;
  logic [CNTW-1:0] pkt_cnt_0;
  logic [CNTW-1:0] pkt_cnt_1;

  modport master (
    output ivalid_0, itype_0, ivalid_1, itype_1, ordy,
    input  sel, grant_0, grant_1, busy, err, pkt_cnt_0, pkt_cnt_1
  );

  modport slave (
    input  ivalid_0, itype_0, ivalid_1, itype_1, ordy,
    output sel, grant_0, grant_1, busy, err, pkt_cnt_0, pkt_cnt_1
  );
endinterface

// File: rtl/mux_pkt_arbiter.sv
// Round-robin wormhole arbiter: HEAD in cycle N locks the output in N+1 until TAIL or watchdog.
// Grants are gated combinationally by ordy; a downstream stall never trips the watchdog.
module mux_pkt_arbiter #(
  parameter int         SELW      = 5,
  parameter logic [1:0] TYPE_NONE = 2'b00,
  parameter logic [1:0] TYPE_HEAD = 2'b01,
  parameter logic [1:0] TYPE_DATA = 2'b10,
  parameter logic [1:0] TYPE_TAIL = 2'b11,
  parameter int         MAX_IDLE  = 8,
  parameter int         CNTW      = 16
) (
  input logic              clk,
  input logic              rst,
  mux_pkt_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  localparam int            IW        = $clog2(MAX_IDLE + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(MAX_IDLE - 1);

  // {is_tail, is_head}
  function automatic logic [1:0] decode(input logic [1:0] t);
    case (t)
      TYPE_HEAD:            decode = 2'b01;
      TYPE_TAIL:            decode = 2'b10;
      TYPE_NONE, TYPE_DATA: decode = 2'b00;
      default:              decode = 2'b00;
    endcase
  endfunction

  state_t          state, state_nxt;
  logic            rr_ptr;
  logic [IW-1:0]   idle_cnt;
  logic            err_q;
  logic [CNTW-1:0] cnt_0, cnt_1;
  logic [1:0]      dec_0, dec_1;
  logic            grant_0, grant_1;
  logic            req_0, req_1;
  logic            tail_0, tail_1;
  logic            own_vld;
  logic            wd_rel;

  assign dec_0   = decode(bus.itype_0);
  assign dec_1   = decode(bus.itype_1);
  assign grant_0 = (state == LOCK0) & bus.ordy;
  assign grant_1 = (state == LOCK1) & bus.ordy;
  assign req_0   = bus.ivalid_0 & dec_0[0];
  assign req_1   = bus.ivalid_1 & dec_1[0];
  assign tail_0  = grant_0 & bus.ivalid_0 & dec_0[1];
  assign tail_1  = grant_1 & bus.ivalid_1 & dec_1[1];
  assign own_vld = ((state == LOCK0) & bus.ivalid_0) | ((state == LOCK1) & bus.ivalid_1);

  always_comb begin
    state_nxt = state;
    wd_rel    = 1'b0;
    case (state)
      IDLE: begin
        if (req_0 && req_1) state_nxt = rr_ptr ? LOCK1 : LOCK0;
        else if (req_0)     state_nxt = LOCK0;
        else if (req_1)     state_nxt = LOCK1;
      end
      LOCK0: begin
        if (tail_0) begin
          state_nxt = IDLE;
        end else if (!bus.ivalid_0 && idle_cnt == IDLE_LAST) begin
          state_nxt = IDLE;
          wd_rel    = 1'b1;
        end
      end
      LOCK1: begin
        if (tail_1) begin
          state_nxt = IDLE;
        end else if (!bus.ivalid_1 && idle_cnt == IDLE_LAST) begin
          state_nxt = IDLE;
          wd_rel    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      idle_cnt <= '0;
      err_q    <= 1'b0;
      cnt_0    <= '0;
      cnt_1    <= '0;
    end else begin
      state <= state_nxt;
      err_q <= wd_rel;
      // Leaving a lock by either route hands priority to the other port.
      if (state != IDLE && state_nxt == IDLE) rr_ptr <= (state == LOCK0);
      if (state == IDLE || state_nxt == IDLE || own_vld) idle_cnt <= '0;
      else                                               idle_cnt <= idle_cnt + IW'(1);
      if (tail_0) cnt_0 <= cnt_0 + CNTW'(1);
      if (tail_1) cnt_1 <= cnt_1 + CNTW'(1);
    end
  end

  assign bus.sel       = {{(SELW-2){1'b0}}, state};
  assign bus.grant_0   = grant_0;
  assign bus.grant_1   = grant_1;
  assign bus.busy      = (state != IDLE);
  assign bus.err       = err_q;
  assign bus.pkt_cnt_0 = cnt_0;
  assign bus.pkt_cnt_1 = cnt_1;

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Randomised bench for mux_pkt_arbiter: a packet-level model predicts every cycle's outputs and
// the order of accepted flits; a negedge monitor pops the scoreboard and compares.
module tb_mux_pkt_arbiter;
  localparam int SELW = 5, CNTW = 16, MAX_IDLE = 8;
  localparam logic [1:0] T_HEAD = 2'b01, T_DATA = 2'b10, T_TAIL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_pkt_arbiter_if #(.SELW(SELW), .CNTW(CNTW)) bus ();
  mux_pkt_arbiter #(.SELW(SELW), .MAX_IDLE(MAX_IDLE), .CNTW(CNTW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [SELW-1:0] sel;
    logic            g0;
    logic            g1;
    logic            busy;
    logic            err;
    logic [CNTW-1:0] c0;
    logic [CNTW-1:0] c1;
  } obs_t;

  int   n_cmp = 0, n_fail = 0;
  obs_t exp_cyc[$];
  int   exp0[$], exp1[$];      // flits each port must get accepted, in order
  int   q0[$], q1[$];          // flits waiting at each sender
  int   pres0 = 0, pres1 = 0;  // flit currently presented
  logic took0 = 1'b0, took1 = 1'b0;
  int   err_seen = 0, g1_seen = 0;
  int   ordy_mode = 0;
  bit   gap_en = 1'b0;
  int   gap0 = 0, gap1 = 0;
  int   next_id = 1;
  int   s0 = 0, s1 = 0;

  // Packet-level model: who owns the output, whose turn on a tie, length of the current silence.
  int   m_owner = -1, m_turn = 0, m_quiet = 0, m_cnt0 = 0, m_cnt1 = 0;
  logic m_err = 1'b0;

  task automatic model_edge();
    int p; logic v; logic [1:0] t; logic h0, h1;
    if (rst) begin
      m_owner = -1; m_turn = 0; m_quiet = 0; m_cnt0 = 0; m_cnt1 = 0; m_err = 1'b0;
      return;
    end
    m_err = 1'b0;
    if (m_owner < 0) begin
      h0 = bus.ivalid_0 && bus.itype_0 == T_HEAD;
      h1 = bus.ivalid_1 && bus.itype_1 == T_HEAD;
      if (h0 && h1) m_owner = m_turn;
      else if (h0)  m_owner = 0;
      else if (h1)  m_owner = 1;
      m_quiet = 0;
    end else begin
      p = m_owner;
      v = (p == 0) ? bus.ivalid_0 : bus.ivalid_1;
      t = (p == 0) ? bus.itype_0 : bus.itype_1;
      if (v && bus.ordy && t == T_TAIL) begin
        if (p == 0) m_cnt0++; else m_cnt1++;
        m_owner = -1; m_turn = 1 - p; m_quiet = 0;
      end else if (v) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == MAX_IDLE) begin
          m_owner = -1; m_turn = 1 - p; m_quiet = 0; m_err = 1'b1;
        end
      end
    end
  endtask

  function automatic obs_t expect_now();
    obs_t e;
    e.sel  = (m_owner == 0) ? SELW'(1) : (m_owner == 1) ? SELW'(2) : '0;
    e.g0   = (m_owner == 0) && bus.ordy;
    e.g1   = (m_owner == 1) && bus.ordy;
    e.busy = (m_owner >= 0);
    e.err  = m_err;
    e.c0   = CNTW'(m_cnt0);
    e.c1   = CNTW'(m_cnt1);
    return e;
  endfunction

  task automatic drive();
    int f;
    if (rst) begin
      q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
      bus.ivalid_0 = 1'b0; bus.ivalid_1 = 1'b0;
      return;
    end
    if (took0 && q0.size() > 0) void'(q0.pop_front());
    if (took1 && q1.size() > 0) void'(q1.pop_front());
    case (ordy_mode)
      0:       bus.ordy = 1'b1;
      1:       bus.ordy = ~bus.ordy;
      default: bus.ordy = 1'($urandom_range(0, 1));
    endcase
    if (q0.size() > 0 && !(gap_en && gap0 < 3 && $urandom_range(0, 3) == 0)) begin
      f = q0[0]; bus.ivalid_0 = 1'b1; bus.itype_0 = f[1:0]; pres0 = f; gap0 = 0;
    end else begin
      bus.ivalid_0 = 1'b0; bus.itype_0 = 2'($urandom); if (q0.size() > 0) gap0++;
    end
    if (q1.size() > 0 && !(gap_en && gap1 < 3 && $urandom_range(0, 3) == 0)) begin
      f = q1[0]; bus.ivalid_1 = 1'b1; bus.itype_1 = f[1:0]; pres1 = f; gap1 = 0;
    end else begin
      bus.ivalid_1 = 1'b0; bus.itype_1 = 2'($urandom); if (q1.size() > 0) gap1++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1 drive();
    #1 if (!rst) exp_cyc.push_back(expect_now());
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_flit(input int p, input logic [1:0] t, input bit accepted);
    int f;
    f = (next_id << 2) | int'(t);
    next_id++;
    if (p == 0) begin q0.push_back(f); if (accepted) exp0.push_back(f); end
    else        begin q1.push_back(f); if (accepted) exp1.push_back(f); end
  endtask

  task automatic send_pkt(input int p, input int nd);
    push_flit(p, T_HEAD, 1'b1);
    repeat (nd) push_flit(p, T_DATA, 1'b1);
    push_flit(p, T_TAIL, 1'b1);
    if (p == 0) s0++; else s1++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && m_owner < 0) && n < budget) begin
      cycle(); n++;
    end
    check({name, "_drained"}, longint'(n < budget), 1);
    run(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    @(negedge clk); #1 rst = 1'b0;
    s0 = 0; s1 = 0;
  endtask

  // Monitor: compares observed outputs and accepted flits against the scoreboard.
  initial begin
    obs_t a, e;
    int   f;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cyc.delete(); took0 = 1'b0; took1 = 1'b0;
      end else begin
        a = {bus.sel, bus.grant_0, bus.grant_1, bus.busy, bus.err, bus.pkt_cnt_0, bus.pkt_cnt_1};
        if (exp_cyc.size() > 0) begin
          e = exp_cyc.pop_front();
          n_cmp++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL outputs(sel,g0,g1,busy,err,cnt0,cnt1) t=%0t actual=%b,%b,%b,%b,%b,%0d,%0d required=%b,%b,%b,%b,%b,%0d,%0d",
                     $time, a.sel, a.g0, a.g1, a.busy, a.err, a.c0, a.c1, e.sel, e.g0, e.g1, e.busy, e.err, e.c0, e.c1);
          end
        end
        took0 = bus.grant_0 && bus.ivalid_0;
        took1 = bus.grant_1 && bus.ivalid_1;
        if (took0) begin
          n_cmp++;
          if (exp0.size() == 0) begin n_fail++; $display("FAIL flit_p0 actual=%0d required=none t=%0t", pres0, $time); end
          else begin f = exp0.pop_front(); if (f != pres0) begin n_fail++; $display("FAIL flit_p0 actual=%0d required=%0d t=%0t", pres0, f, $time); end end
        end
        if (took1) begin
          n_cmp++;
          if (exp1.size() == 0) begin n_fail++; $display("FAIL flit_p1 actual=%0d required=none t=%0t", pres1, $time); end
          else begin f = exp1.pop_front(); if (f != pres1) begin n_fail++; $display("FAIL flit_p1 actual=%0d required=%0d t=%0t", pres1, f, $time); end end
        end
        if (bus.err) err_seen++;
        if (bus.grant_1) g1_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int g, e, c0, n;
    bus.ivalid_0 = 1'b0; bus.itype_0 = 2'b00;
    bus.ivalid_1 = 1'b0; bus.itype_1 = 2'b00;
    bus.ordy = 1'b1;
    run(3);
    check("rst_sel", bus.sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_grant0", bus.grant_0, 0);
    check("rst_cnt0", bus.pkt_cnt_0, 0);
    check("rst_cnt1", bus.pkt_cnt_1, 0);
    @(negedge clk); #1 rst = 1'b0;

    // Port 1 alone: HEAD + 20 DATA + TAIL.
    g = g1_seen;
    send_pkt(1, 20);
    wait_idle("t1", 100);
    check("t1_grant1_cycles", g1_seen - g, 22);
    check("t1_cnt1", bus.pkt_cnt_1, 1);

    // Simultaneous HEADs after reset, five packets each side.
    do_reset();
    for (int i = 0; i < 5; i++) begin send_pkt(0, 2); send_pkt(1, 3); end
    wait_idle("t2", 300);
    check("t2_cnt0", bus.pkt_cnt_0, 5);
    check("t2_cnt1", bus.pkt_cnt_1, 5);

    // ordy toggling every cycle.
    ordy_mode = 1;
    e = err_seen;
    send_pkt(0, 9);
    wait_idle("t3", 100);
    check("t3_err", err_seen - e, 0);
    check("t3_cnt0", bus.pkt_cnt_0, 6);
    ordy_mode = 0;

    // Abandoned packet on port 0 with port 1 waiting.
    e = err_seen; c0 = bus.pkt_cnt_0;
    push_flit(0, T_HEAD, 1'b1);
    n = 0;
    while (q0.size() > 0 && n < 20) begin cycle(); n++; end
    check("t4_head_taken", longint'(n < 20), 1);
    send_pkt(1, 2);
    wait_idle("t4", 60);
    check("t4_err_cycles", err_seen - e, 1);
    check("t4_cnt0", bus.pkt_cnt_0, c0);
    check("t4_cnt1", bus.pkt_cnt_1, 6);

    // Stray DATA in IDLE.
    g = g1_seen;
    push_flit(1, T_DATA, 1'b0);
    run(10);
    check("t5_grant1", g1_seen - g, 0);
    check("t5_sel", bus.sel, 0);
    q1.delete();
    run(2);

    // Random traffic, random ordy, short source gaps.
    ordy_mode = 2; gap_en = 1'b1;
    repeat (40) send_pkt(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
    wait_idle("rand", 4000);
    check("rand_cnt0", bus.pkt_cnt_0, s0);
    check("rand_cnt1", bus.pkt_cnt_1, s1);
    check("exp_left", exp0.size() + exp1.size(), 0);
    ordy_mode = 0; gap_en = 1'b0;
    run(2);

    // Reset asserted inside a port 1 packet.
    send_pkt(1, 10);
    run(4);
    check("t6_busy_pre", bus.busy, 1);
    check("t6_grant1_pre", bus.grant_1, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_sel_async", bus.sel, 0);
    check("t6_grant1_async", bus.grant_1, 0);
    check("t6_busy_async", bus.busy, 0);
    cycle();
    @(negedge clk); #1 rst = 1'b0;
    run(3);
    check("t6_cnt1_after", bus.pkt_cnt_1, 0);
    check("t6_busy_after", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
